serial_adder_ctrl: RTL and testbench

//  Bit-serial adder controller: time-multiplexes one full_adder cell
//  (ports a, b, cin, sum, cout) to add two WIDTH-bit operands plus carry-in.
//  It processes one bit per clock, LSB first, with a start/busy/done handshake.
//  It sits between a requesting datapath and the shared 1-bit full_adder.

---
 rtl/serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder cell adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
// Start is taken only in IDLE; busy for WIDTH cycles, then a one-cycle done; start during RUN/DONE is dropped, not queued.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 bits already produced; the final bit comes straight from the cell.
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             load;
  logic             step;
  logic             last;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_nxt;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign sum_nxt = {fa_sum, sum_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= sum_nxt[WIDTH-1:1];
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers move only on the last-bit edge so they stay stable through the next op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (step && last) begin
      sum  <= sum_nxt;
      cout <= fa_cout;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4, checked against a plain-arithmetic model.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel4 = 1'b0;
  logic [7:0] a_d = '0;
  logic [7:0] b_d = '0;
  logic       cin_d = 1'b0;

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  logic       busy_m, done_m, cout_m;
  logic [7:0] sum_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start & ~sel4),
    .a     (a_d),
    .b     (b_d),
    .cin   (cin_d),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start & sel4),
    .a     (a_d[3:0]),
    .b     (b_d[3:0]),
    .cin   (cin_d),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  assign busy_m = sel4 ? busy4 : busy8;
  assign done_m = sel4 ? done4 : done8;
  assign cout_m = sel4 ? cout4 : cout8;
  assign sum_m  = sel4 ? {4'h0, sum4} : sum8;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_w();
    return sel4 ? 4 : 8;
  endfunction

  // {cout,sum} expected as one integer: a + b + cin over the active width
  function automatic int model(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int mask;
    mask = (1 << cur_w()) - 1;
    return (int'(av) & mask) + (int'(bv) & mask) + int'(cv);
  endfunction

  task automatic pulse_rst_check();
    rst = 1'b1;
    #1;
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_sum",  sum_m, 0);
    check("rst_cout", cout_m, 0);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input int ign_at, input int rst_at);
    int         w, tot, n;
    logic [7:0] prev_sum;
    logic       prev_cout;
    bit         aborted;
    w       = cur_w();
    tot     = model(av, bv, cv);
    aborted = 1'b0;
    @(negedge clk);
    a_d = av; b_d = bv; cin_d = cv; start = 1'b1;
    prev_sum  = sum_m;
    prev_cout = cout_m;
    @(negedge clk);
    start = 1'b0;
    a_d = 8'($urandom); b_d = 8'($urandom); cin_d = 1'($urandom);
    check("sum_hold",  sum_m, prev_sum);
    check("cout_hold", cout_m, prev_cout);
    n = 0;
    while (busy_m && n < 40 && !aborted) begin
      n++;
      if (n == ign_at) begin
        start = 1'b1; a_d = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (n == rst_at) begin
        pulse_rst_check();
        aborted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (aborted) begin
      repeat (w + 3) begin
        @(negedge clk);
        check("no_done_after_rst", done_m, 0);
      end
    end else begin
      check("busy_cycles", n, w);
      check("done_pulse", done_m, 1);
      check("done_busy_low", busy_m, 0);
      check("sum",  sum_m, tot & ((1 << w) - 1));
      check("cout", cout_m, tot >> w);
      @(negedge clk);
      check("done_one_cycle", done_m, 0);
      check("idle_busy", busy_m, 0);
    end
  endtask

  task automatic held_start_test();
    logic [16:0] q[$];
    logic [16:0] e;
    int          cyc, last_done, ndone, w, tot;
    w = cur_w();
    cyc = 0; last_done = -1; ndone = 0;
    @(negedge clk);
    a_d = 8'($urandom); b_d = 8'($urandom); cin_d = 1'($urandom);
    start = 1'b1;
    while (ndone < 3 && cyc < 200) begin
      if (!busy_m && !done_m) begin
        q.push_back({cin_d, b_d, a_d});
      end else if (busy_m) begin
        a_d = 8'($urandom); b_d = 8'($urandom); cin_d = 1'($urandom);
      end
      if (done_m) begin
        check("held_queue", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e   = q.pop_front();
          tot = model(e[7:0], e[15:8], e[16]);
          check("held_sum",  sum_m, tot & ((1 << w) - 1));
          check("held_cout", cout_m, tot >> w);
        end
        if (last_done >= 0) check("done_spacing", cyc - last_done, w + 2);
        last_done = cyc;
        ndone++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("held_ops", ndone, 3);
    repeat (w + 3) @(negedge clk);
  endtask

  initial begin
    #12;
    check("init_busy8", busy8, 0);
    check("init_done8", done8, 0);
    check("init_sum8",  sum8, 0);
    check("init_sum4",  sum4, 0);
    rst = 1'b0;

    sel4 = 1'b0;
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 0);
    run_op(8'h12, 8'h34, 1'b0, 0, 0);

    // asynchronous reset away from any clock edge
    @(posedge clk);
    #2;
    pulse_rst_check();
    sel4 = 1'b1;
    #0 check("rst_sum4", sum_m, 0);
    sel4 = 1'b0;

    run_op(8'h3C, 8'h42, 1'b0, 3, 0);
    run_op(8'h77, 8'h11, 1'b1, 0, 4);
    check("after_rst_sum", sum_m, 0);
    run_op(8'h80, 8'h80, 1'b1, 0, 0);

    held_start_test();
    repeat (500) run_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

    sel4 = 1'b1;
    run_op(8'h0F, 8'h0F, 1'b1, 0, 0);
    run_op(8'h09, 8'h03, 1'b0, 2, 0);
    held_start_test();
    repeat (500) run_op(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
